vga_timing_out: RTL and testbench

VGA_TIMING_OUT -- requirements
Module: vga_timing_out

---
 rtl/vga_timing_out.sv | 147 ++++++++++++++
 tb/tb_vga_timing_out.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_out.sv
// VGA raster timing: free-running x/y counters, sync decode, and a delay line
// that keeps the registered syncs aligned with the downstream shaded colour.
module vga_timing_out #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   COLOR_W    = 4,
    parameter int   PIPE_DELAY = 2,
    parameter int   CNT_W      = 12
) (
    input  logic               clk_pix,
    input  logic               reset,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               active,
    output logic               frame_start,
    output logic               line_start,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic             SYNC_OFF = ~SYNC_POL;

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             h_wrap;
    logic             active_c, hs_c, vs_c;

    always_comb begin
        h_wrap = (x_q == H_LAST);
        x_d    = h_wrap ? '0 : x_q + ONE;
        y_d    = y_q;
        if (h_wrap) begin
            y_d = (y_q == V_LAST) ? '0 : y_q + ONE;
        end
    end

    always_comb begin
        active_c = (x_q < H_ACT) && (y_q < V_ACT);
        hs_c     = (x_q >= H_SS && x_q < H_SE) ? SYNC_POL : SYNC_OFF;
        vs_c     = (y_q >= V_SS && y_q < V_SE) ? SYNC_POL : SYNC_OFF;
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_c;
    assign line_start  = ~reset & (x_q == '0);
    assign frame_start = ~reset & (x_q == '0) & (y_q == '0);

    logic act_dly, hs_dly, vs_dly;

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign act_dly = active_c;
            assign hs_dly  = hs_c;
            assign vs_dly  = vs_c;
        end else begin : g_dly
            logic [PIPE_DELAY-1:0] act_q, act_d;
            logic [PIPE_DELAY-1:0] hs_q, hs_d;
            logic [PIPE_DELAY-1:0] vs_q, vs_d;

            always_comb begin
                act_d = (act_q << 1) | PIPE_DELAY'(active_c);
                hs_d  = (hs_q << 1) | PIPE_DELAY'(hs_c);
                vs_d  = (vs_q << 1) | PIPE_DELAY'(vs_c);
            end

            // Reset flushes the line so pre-reset state never leaks out.
            always_ff @(posedge clk_pix or posedge reset) begin
                if (reset) begin
                    act_q <= '0;
                    hs_q  <= {PIPE_DELAY{SYNC_OFF}};
                    vs_q  <= {PIPE_DELAY{SYNC_OFF}};
                end else begin
                    act_q <= act_d;
                    hs_q  <= hs_d;
                    vs_q  <= vs_d;
                end
            end

            assign act_dly = act_q[PIPE_DELAY-1];
            assign hs_dly  = hs_q[PIPE_DELAY-1];
            assign vs_dly  = vs_q[PIPE_DELAY-1];
        end
    endgenerate

    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hso_q, hso_d, vso_q, vso_d;

    always_comb begin
        r_d   = act_dly ? r : '0;
        g_d   = act_dly ? g : '0;
        b_d   = act_dly ? b : '0;
        hso_d = hs_dly;
        vso_d = vs_dly;
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hso_q <= SYNC_OFF;
            vso_q <= SYNC_OFF;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hso_q <= hso_d;
            vso_q <= vso_d;
        end
    end

    assign vga_r     = r_q;
    assign vga_g     = g_q;
    assign vga_b     = b_q;
    assign vga_hsync = hso_q;
    assign vga_vsync = vso_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: default-timing instance plus a tiny zero-delay,
// active-high-sync instance, both checked from a cycle-indexed scoreboard.
module tb_vga_timing_out;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, pd;
        bit pol;
    } cfg_t;

    typedef struct {
        int x, y;
        bit act, fs, ls, hs, vs;
        logic [3:0] vr, vg, vb;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] r = 4'hF, g = 4'hF, b = 4'hF;

    logic [11:0] xa, ya, xb, yb;
    logic act_a, fs_a, ls_a, hs_a, vs_a;
    logic act_b, fs_b, ls_b, hs_b, vs_b;
    logic [3:0] ra, ga, ba, rb, gb, bb;

    always #5 clk = ~clk;

    vga_timing_out u_a (
        .clk_pix(clk), .reset(reset), .x(xa), .y(ya), .active(act_a),
        .frame_start(fs_a), .line_start(ls_a), .r(r), .g(g), .b(b),
        .vga_r(ra), .vga_g(ga), .vga_b(ba),
        .vga_hsync(hs_a), .vga_vsync(vs_a)
    );

    vga_timing_out #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b1), .PIPE_DELAY(0)
    ) u_b (
        .clk_pix(clk), .reset(reset), .x(xb), .y(yb), .active(act_b),
        .frame_start(fs_b), .line_start(ls_b), .r(r), .g(g), .b(b),
        .vga_r(rb), .vga_g(gb), .vga_b(bb),
        .vga_hsync(hs_b), .vga_vsync(vs_b)
    );

    cfg_t ca = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
    cfg_t cb = '{8, 2, 3, 3, 4, 1, 2, 1, 0, 1'b1};

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cur_c = 0;
    bit   in_rst = 1'b1;
    bit   mon_en = 1'b0;
    int   seg = 0;
    logic [3:0] rp = 4'hF, gp = 4'hF, bp = 4'hF;

    function automatic exp_t model(cfg_t c, int cyc, bit rst,
                                   logic [3:0] pr, logic [3:0] pg,
                                   logic [3:0] pb);
        exp_t e;
        int ht, vt, t, xt, yt;
        bit off;
        off = ~c.pol;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        e.x = rst ? 0 : cyc % ht;
        e.y = rst ? 0 : (cyc / ht) % vt;
        e.act = (e.x < c.ha) && (e.y < c.va);
        e.ls = !rst && e.x == 0;
        e.fs = e.ls && e.y == 0;
        e.hs = off;
        e.vs = off;
        e.vr = 4'h0;
        e.vg = 4'h0;
        e.vb = 4'h0;
        if (!rst && cyc > c.pd) begin
            t = cyc - c.pd - 1;
            xt = t % ht;
            yt = (t / ht) % vt;
            if (xt >= c.ha + c.hf && xt < c.ha + c.hf + c.hs) e.hs = c.pol;
            if (yt >= c.va + c.vf && yt < c.va + c.vf + c.vs) e.vs = c.pol;
            if (xt < c.ha && yt < c.va) begin
                e.vr = pr;
                e.vg = pg;
                e.vb = pb;
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s seg=%0d cyc=%0d rst=%0d got=%0d exp=%0d",
                     nm, seg, cur_c, in_rst, act, exp);
        end
    endtask

    task automatic chk_dut(string p, exp_t e, logic [11:0] dx,
                           logic [11:0] dy, logic da, logic dfs,
                           logic dls, logic [3:0] dr, logic [3:0] dg,
                           logic [3:0] db, logic dhs, logic dvs);
        chk({p, "_x"}, int'(dx), e.x);
        chk({p, "_y"}, int'(dy), e.y);
        chk({p, "_active"}, int'(da), int'(e.act));
        chk({p, "_frame_start"}, int'(dfs), int'(e.fs));
        chk({p, "_line_start"}, int'(dls), int'(e.ls));
        chk({p, "_vga_r"}, int'(dr), int'(e.vr));
        chk({p, "_vga_g"}, int'(dg), int'(e.vg));
        chk({p, "_vga_b"}, int'(db), int'(e.vb));
        chk({p, "_hsync"}, int'(dhs), int'(e.hs));
        chk({p, "_vsync"}, int'(dvs), int'(e.vs));
    endtask

    // One clock: apply reset level, enqueue expectations, drive next colour.
    task automatic step(bit rst_v, bit use_pat);
        logic [3:0] rv;
        @(posedge clk);
        #1;
        if (!in_rst) cur_c++;
        if (rst_v) begin
            reset = 1'b1;
            in_rst = 1'b1;
            cur_c = 0;
        end else if (in_rst) begin
            reset = 1'b0;
            in_rst = 1'b0;
            cur_c = 0;
        end
        qa.push_back(model(ca, cur_c, in_rst, rp, gp, bp));
        qb.push_back(model(cb, cur_c, in_rst, rp, gp, bp));
        mon_en = 1'b1;
        if (!use_pat) rv = 4'hF;
        else if (cur_c == 2) rv = 4'hA;
        else if (cur_c == 642) rv = 4'h5;
        else rv = 4'(cur_c * 7 + 3);
        r = rv;
        g = use_pat ? 4'(cur_c) : 4'hF;
        b = ~rv;
        rp = r;
        gp = g;
        bp = b;
    endtask

    int hs_low = 0;
    int first_low = -1;
    int fs_cnt = 0;
    int vs_hi = 0;

    always @(negedge clk) begin
        exp_t ea, eb;
        if (mon_en) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk_dut("a", ea, xa, ya, act_a, fs_a, ls_a,
                        ra, ga, ba, hs_a, vs_a);
                chk_dut("b", eb, xb, yb, act_b, fs_b, ls_b,
                        rb, gb, bb, hs_b, vs_b);
            end
            if (!in_rst && seg == 0) begin
                if (cur_c == 3) chk("a_r_first_pixel", int'(ra), 10);
                if (cur_c == 643) chk("a_r_blanked", int'(ra), 0);
                if (cur_c >= 3 && cur_c < 803 && !hs_a) begin
                    hs_low++;
                    if (first_low < 0) first_low = cur_c;
                end
                if (cur_c == 803) begin
                    chk("a_hsync_low_cnt", hs_low, 96);
                    chk("a_hsync_first_low", first_low, 659);
                end
                if (cur_c < 1664 && fs_b) fs_cnt++;
                if (cur_c == 1664) chk("b_frame_start_cnt", fs_cnt, 13);
                if (cur_c >= 1 && cur_c <= 128 && vs_b) vs_hi++;
                if (cur_c == 129) chk("b_vsync_high_cnt", vs_hi, 32);
            end
            if (in_rst) begin
                chk("a_rst_hsync", int'(hs_a), 1);
                chk("a_rst_frame_start", int'(fs_a), 0);
            end
            if (!in_rst && seg == 1 && cur_c <= 2) begin
                chk("a_post_rst_r", int'(ra), 0);
                chk("a_post_rst_hsync", int'(hs_a), 1);
                chk("a_post_rst_vsync", int'(vs_a), 1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b1);
        seg = 1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 900; i++) step(1'b0, 1'b1);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("sb_a_drained", qa.size(), 0);
        chk("sb_b_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
